// File: rtl/seq_div_if.sv
// Handshake/bus bundle for the sequential divider: request side (start, A, B)
// and result side (Q, R, flags, busy/done).
interface seq_div_if #(
  parameter int M = 4
);
  logic         start;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [M-1:0] Q;
  logic [M-1:0] R;
  logic         busy;
  logic         done;
  logic         C;
  logic         N;
  logic         V;
  logic         Z;

  // Requester drives operands and start, observes results.
  modport master (
    output start, A, B,
    input  Q, R, busy, done, C, N, V, Z
  );

  // Divider consumes the request and drives the results.
  modport slave (
    input  start, A, B,
    output Q, R, busy, done, C, N, V, Z
  );
endinterface

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// IDLE -> RUN (M iterations) -> DONE (one-cycle done pulse) -> IDLE.
// Divide-by-zero skips RUN and lands in DONE on the accepting edge.
module seq_div #(
  parameter int M = 4
) (
  input  logic      clk,
  input  logic      rst,
  seq_div_if.slave  bus
);
  localparam int CW = $clog2(M) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [M-1:0]  a_q, a_d;     // dividend bits shift out MSB-first, quotient bits shift in
  logic [M-1:0]  b_q, b_d;     // latched divisor
  logic [M-1:0]  p_q, p_d;     // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  q_q, q_d;
  logic [M-1:0]  r_q, r_d;
  logic          c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [M:0]    rem_sh;
  logic [M:0]    trial;
  logic          qbit;
  logic [M-1:0]  p_nx;
  logic [M-1:0]  quo_nx;

  // One restoring step: shift in next dividend bit, trial-subtract at M+1 bits.
  // On a negative trial the shifted value is < B, so it fits back in M bits.
  always_comb begin
    rem_sh = {p_q, a_q[M-1]};
    trial  = rem_sh - {1'b0, b_q};
    qbit   = ~trial[M];
    p_nx   = qbit ? trial[M-1:0] : rem_sh[M-1:0];
    quo_nx = {a_q[M-2:0], qbit};
  end

  // Next-state and result logic; results only move on the final step or the /0 path.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.B != '0) begin
            a_d     = bus.A;
            b_d     = bus.B;
            p_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            // Divide-by-zero fast path: flags still follow the usual formulas.
            q_d     = '1;
            r_d     = bus.A;
            c_d     = |bus.A;
            n_d     = 1'b1;
            z_d     = 1'b0;
            v_d     = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        a_d   = quo_nx;
        p_d   = p_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(M - 1)) begin
          q_d     = quo_nx;
          r_d     = p_nx;
          c_d     = |p_nx;
          n_d     = quo_nx[M-1];
          z_d     = ~|quo_nx;
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.C    = c_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (M=4): directed cases plus randomized
// operands, checked against a plain-arithmetic reference model.
module tb_seq_div;
  localparam int M = 4;
  localparam int MAXV = (1 << M) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  // Model of the last registered result (outputs hold it between operations).
  int   m_q = 0, m_r = 0, m_c = 0, m_n = 0, m_v = 0, m_z = 0;

  seq_div_if #(.M(M)) bus ();

  seq_div #(.M(M)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_result(input string pfx);
    chk({pfx, "_q"}, 32'(bus.Q), 32'(m_q));
    chk({pfx, "_r"}, 32'(bus.R), 32'(m_r));
    chk({pfx, "_c"}, 32'(bus.C), 32'(m_c));
    chk({pfx, "_n"}, 32'(bus.N), 32'(m_n));
    chk({pfx, "_v"}, 32'(bus.V), 32'(m_v));
    chk({pfx, "_z"}, 32'(bus.Z), 32'(m_z));
  endtask

  // Reference: unsigned division with the /0 convention Q=all ones, R=A.
  task automatic model(input int a, input int b);
    if (b == 0) begin
      m_q = MAXV;
      m_r = a;
      m_v = 1;
    end else begin
      m_q = a / b;
      m_r = a % b;
      m_v = 0;
    end
    m_z = (m_q == 0) ? 1 : 0;
    m_n = (m_q >= (1 << (M - 1))) ? 1 : 0;
    m_c = (m_r != 0) ? 1 : 0;
  endtask

  // One full operation. With noise set, start is held high with other operands
  // throughout RUN and the DONE cycle; those requests must all be ignored.
  task automatic do_div(input int a, input int b, input bit noise, input int na, input int nb);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = M'(a);
    bus.B     = M'(b);
    @(posedge clk); #1;
    if (noise) begin
      bus.start = 1'b1;
      bus.A     = M'(na);
      bus.B     = M'(nb);
    end else begin
      bus.start = 1'b0;
      bus.A     = M'($urandom);
      bus.B     = M'($urandom);
    end
    chk("busy_rise", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      chk("hold_q", 32'(bus.Q), 32'(m_q));
      @(posedge clk); #1;
      lat++;
    end
    model(a, b);
    chk("latency", 32'(lat), (b == 0) ? 32'd0 : 32'(M));
    chk("done_hi", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd1);
    chk_result("res");
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("busy_fall", 32'(bus.busy), 32'd0);
    chk("hold_after", 32'(bus.Q), 32'(m_q));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_result("rst");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_div(13, 3, 1'b0, 0, 0);
    do_div(2, 5, 1'b0, 0, 0);
    do_div(15, 1, 1'b0, 0, 0);
    do_div(9, 0, 1'b0, 0, 0);
    do_div(0, 7, 1'b0, 0, 0);
    do_div(0, 0, 1'b0, 0, 0);
    do_div(13, 3, 1'b1, 7, 2);
    do_div(7, 2, 1'b0, 0, 0);
    do_div(5, 0, 1'b1, 7, 2);

    // Reset during RUN: abort, clear result, no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = M'(14);
    bus.B     = M'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q = 0; m_r = 0; m_c = 0; m_n = 0; m_v = 0; m_z = 0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk_result("abort");
    repeat (M + 1) begin
      @(posedge clk); #1;
      chk("abort_nodone", 32'(bus.done), 32'd0);
    end
    do_div(14, 4, 1'b0, 0, 0);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = M'(11);
    bus.B     = M'(2);
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    m_q = 0; m_r = 0; m_c = 0; m_n = 0; m_v = 0; m_z = 0;
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    chk_result("rst_start");

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      int a, b;
      a = int'($urandom_range(0, MAXV));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MAXV));
      do_div(a, b, bit'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)),
             int'($urandom_range(0, MAXV)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
